// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch port between the sequencer (master) and instruction memory (slave).
// The sequencer holds imem_req for the whole fetch; memory answers with imem_ready plus data.
interface cpu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [15:0]     imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 4-bit core.
// Owns pc, IR and the retired counter; every output is decoded from registered state (Moore).
module cpu_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  cpu_sequencer_if.master        imem,
  output logic [3:0]             dec_opcode,
  output logic [3:0]             dec_funct,
  output logic [1:0]             rf_rd,
  output logic [1:0]             rf_rs1,
  output logic [1:0]             rf_rs2,
  output logic                   alu_en,
  output logic                   rf_we,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegal,
  output logic [7:0]             retired
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [7:0]      retired_q, retired_d;
  logic            ill_q, ill_d;

  logic            ir_is_legal;
  logic            ir_is_halt;
  logic            req_out;
  logic            unused_ir_bits;

  // funct[3] marks the reserved half of the R-type space, which is treated as illegal.
  assign ir_is_legal    = (ir_q[15:12] == OP_RTYPE) && !ir_q[11];
  assign ir_is_halt     = (ir_q[15:12] == OP_HALT);
  assign unused_ir_bits = ^ir_q[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      ill_q     <= ill_d;
    end
  end

  // Next-state and datapath-register update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    ill_d     = ill_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem.imem_ready) begin
          ir_d    = imem.imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_is_legal) begin
          ill_d   = 1'b0;
          state_d = S_EXECUTE;
        end else if (ir_is_halt) begin
          state_d = S_HALT;
        end else begin
          ill_d   = 1'b1;
          state_d = S_WRITEBACK;
        end
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        // Both counters wrap naturally at their register width.
        pc_d      = pc_q + PC_W'(1);
        retired_d = retired_q + 8'd1;
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode.
  always_comb begin
    req_out = 1'b0;
    alu_en  = 1'b0;
    rf_we   = 1'b0;
    illegal = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_FETCH: begin
        busy    = 1'b1;
        req_out = 1'b1;
      end
      S_DECODE: begin
        busy = 1'b1;
      end
      S_EXECUTE: begin
        busy   = 1'b1;
        alu_en = 1'b1;
      end
      S_WRITEBACK: begin
        busy    = 1'b1;
        rf_we   = !ill_q;
        illegal = ill_q;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign imem.imem_req  = req_out;
  assign imem.imem_addr = pc_q;

  assign dec_opcode = ir_q[15:12];
  assign dec_funct  = ir_q[11:8];
  assign rf_rd      = ir_q[7:6];
  assign rf_rs1     = ir_q[5:4];
  assign rf_rs2     = ir_q[3:2];
  assign retired    = retired_q;

endmodule
